// File: rtl/shift_seq_ctrl.sv
// LED-bank shift register sequencer: manual bit requests, tick-driven pattern playback,
// shadow copy of the register and pattern match. Optional macro SHIFT_CNT_EN adds shift_cnt.
module shift_seq_ctrl #(
  parameter int                 PAT_W      = 8,
  parameter int                 STEP_TICKS = 250,
  parameter int                 MATCH_W    = 7,
  parameter logic [MATCH_W-1:0] MATCH_PAT  = 7'b1011001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             req_one,
  input  logic             req_zero,
  input  logic             mode_tgl,
  input  logic             stop,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pat_in,
  output logic             sh_din,
  output logic             sh_en,
  output logic [1:0]       state,
  output logic             pending,
  output logic             load_err,
  output logic [PAT_W-1:0] shadow,
`ifdef SHIFT_CNT_EN
  output logic [15:0]      shift_cnt,
`endif
  output logic             match
);

  localparam int               IDX_W     = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [15:0]      STEP_LAST = 16'(STEP_TICKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [PAT_W-1:0] pat_r;
  logic [IDX_W-1:0] idx_r;
  logic [15:0]      step_cnt_r;
  logic             slot_v_r;
  logic             slot_bit_r;
  logic             step_due_r;

  logic [1:0]       state_s;
  logic [PAT_W-1:0] pat_s;
  logic [IDX_W-1:0] idx_s;
  logic [15:0]      step_cnt_s;
  logic             slot_v_s;
  logic             slot_bit_s;
  logic             step_due_s;
  logic             emit_s;
  logic             emit_bit_s;
  logic             req_v_s;

  assign req_v_s = req_one | req_zero;

  // Next-state decode: FSM, manual slot, step timing and the bit to shift this edge
  always_comb begin
    state_s    = state;
    pat_s      = pat_r;
    idx_s      = idx_r;
    step_cnt_s = step_cnt_r;
    slot_v_s   = slot_v_r;
    slot_bit_s = slot_bit_r;
    step_due_s = step_due_r;
    emit_s     = 1'b0;
    emit_bit_s = 1'b0;
    if (stop) begin
      state_s    = ST_IDLE;
      slot_v_s   = 1'b0;
      step_due_s = 1'b0;
    end else begin
      // Every request lands in the slot first; a newer one overwrites an older one
      if (req_v_s) begin
        slot_v_s   = 1'b1;
        slot_bit_s = req_one;
      end else begin
        slot_v_s   = slot_v_r;
        slot_bit_s = slot_bit_r;
      end
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (load_pat) begin
            pat_s = pat_in;
            idx_s = IDX_TOP;
          end else begin
            pat_s = pat_r;
          end
          // A shift right after another one waits a cycle in the slot
          if (slot_v_s && !sh_en) begin
            emit_s     = 1'b1;
            emit_bit_s = slot_bit_s;
            slot_v_s   = 1'b0;
          end else begin
            emit_s = 1'b0;
          end
          if (mode_tgl) begin
            state_s = ST_PLAY;
            if (state == ST_IDLE) begin
              step_cnt_s = 16'd0;
              idx_s      = IDX_TOP;
              step_due_s = 1'b0;
            end else begin
              step_cnt_s = step_cnt_r;
            end
          end else begin
            state_s = state;
          end
        end
        ST_PLAY: begin
          if (mode_tgl) begin
            state_s = ST_HOLD;
            if (slot_v_s && !sh_en) begin
              emit_s     = 1'b1;
              emit_bit_s = slot_bit_s;
              slot_v_s   = 1'b0;
            end else begin
              emit_s = 1'b0;
            end
          end else begin
            if (tick) begin
              if (step_cnt_r == STEP_LAST) begin
                step_cnt_s = 16'd0;
                step_due_s = 1'b1;
              end else begin
                step_cnt_s = step_cnt_r + 16'd1;
              end
            end else begin
              step_cnt_s = step_cnt_r;
            end
            // A queued manual bit takes the place of the pattern bit; idx then holds
            if (step_due_s && !sh_en) begin
              emit_s     = 1'b1;
              step_due_s = 1'b0;
              if (slot_v_s) begin
                emit_bit_s = slot_bit_s;
                slot_v_s   = 1'b0;
              end else begin
                emit_bit_s = pat_r[idx_r];
                idx_s      = (idx_r == IDX_ZERO) ? IDX_TOP : (idx_r - IDX_ONE);
              end
            end else begin
              emit_s = 1'b0;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pat_r      <= {PAT_W{1'b0}};
      idx_r      <= IDX_TOP;
      step_cnt_r <= 16'd0;
      slot_v_r   <= 1'b0;
      slot_bit_r <= 1'b0;
      step_due_r <= 1'b0;
      sh_en      <= 1'b0;
      sh_din     <= 1'b0;
      pending    <= 1'b0;
      load_err   <= 1'b0;
      shadow     <= {PAT_W{1'b0}};
      match      <= 1'b0;
    end else begin
      state      <= state_s;
      pat_r      <= pat_s;
      idx_r      <= idx_s;
      step_cnt_r <= step_cnt_s;
      slot_v_r   <= slot_v_s;
      slot_bit_r <= slot_bit_s;
      step_due_r <= step_due_s;
      sh_en      <= emit_s;
      sh_din     <= emit_bit_s;
      pending    <= slot_v_s && (state_s == ST_PLAY);
      load_err   <= load_pat && (state == ST_PLAY);
      if (emit_s) begin
        shadow <= {shadow[PAT_W-2:0], emit_bit_s};
      end
      match      <= (shadow[MATCH_W-1:0] == MATCH_PAT);
    end
  end

`ifdef SHIFT_CNT_EN
  // Saturating count of emitted shifts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= 16'd0;
    end else if (stop) begin
      shift_cnt <= 16'd0;
    end else if (emit_s && (shift_cnt != 16'hFFFF)) begin
      shift_cnt <= shift_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector table, async-reset sequence and
// randomized stimulus against a behavioural model (STEP_TICKS=2).
module tb_shift_seq_ctrl;

  localparam int STEP = 2;

  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] TK = 6'b100000;
  localparam logic [5:0] R1 = 6'b010000;
  localparam logic [5:0] R0 = 6'b001000;
  localparam logic [5:0] MD = 6'b000100;
  localparam logic [5:0] SP = 6'b000010;
  localparam logic [5:0] LD = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, req_one = 1'b0, req_zero = 1'b0;
  logic       mode_tgl = 1'b0, stop = 1'b0, load_pat = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic       sh_din, sh_en, pending, load_err, match;
  logic [1:0] state;
  logic [7:0] shadow;
`ifdef SHIFT_CNT_EN
  logic [15:0] shift_cnt;
`endif

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.PAT_W(8), .STEP_TICKS(STEP), .MATCH_W(7), .MATCH_PAT(7'b1011001)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req_one(req_one), .req_zero(req_zero),
    .mode_tgl(mode_tgl), .stop(stop), .load_pat(load_pat), .pat_in(pat_in),
    .sh_din(sh_din), .sh_en(sh_en), .state(state), .pending(pending),
    .load_err(load_err), .shadow(shadow),
`ifdef SHIFT_CNT_EN
    .shift_cnt(shift_cnt),
`endif
    .match(match)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] ins;
    logic [7:0] pat;
    logic [1:0] en_din;
    logic [1:0] st;
    logic [1:0] pd_le;
    logic [7:0] sh;
    logic       m;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [5:0] ins, input logic [7:0] pat, input logic [1:0] en_din,
                              input logic [1:0] st, input logic [1:0] pd_le, input logic [7:0] sh,
                              input logic m);
    vec_t v;
    v.ins = ins; v.pat = pat; v.en_din = en_din; v.st = st; v.pd_le = pd_le; v.sh = sh; v.m = m;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ins, input logic [7:0] p);
    {tick, req_one, req_zero, mode_tgl, stop, load_pat} = ins;
    pat_in = p;
  endtask

  task automatic do_reset();
    drive(NO, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({sh_din, sh_en, state, pending, load_err, shadow, match}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference model
  int       m_mode, m_idx, m_cnt, m_scnt;
  bit       m_pv, m_pb, m_en, m_din, m_lerr, m_match;
  bit [7:0] m_pat, m_shadow;

  task automatic model_reset();
    m_mode = 0; m_idx = 7; m_cnt = 0; m_scnt = 0;
    m_pv = 1'b0; m_pb = 1'b0; m_en = 1'b0; m_din = 1'b0; m_lerr = 1'b0; m_match = 1'b0;
    m_pat = 8'h00; m_shadow = 8'h00;
  endtask

  task automatic model_step(input logic [5:0] ins, input logic [7:0] p);
    bit tk, r1, r0, md, sp, ld, req, em, b;
    {tk, r1, r0, md, sp, ld} = ins;
    req = r1 | r0;
    em = 1'b0;
    b = 1'b0;
    m_match = ((m_shadow & 8'h7F) == 8'h59);
    m_lerr = ld && (m_mode == 1);
    if (sp) begin
      m_mode = 0; m_pv = 1'b0; m_scnt = 0;
    end else if (m_mode != 1) begin
      if (ld) begin m_pat = p; m_idx = 7; end
      if (req) begin em = 1'b1; b = r1; end
      if (md) begin
        if (m_mode == 0) begin m_cnt = 0; m_idx = 7; end
        m_mode = 1;
      end
    end else begin
      if (req) begin m_pv = 1'b1; m_pb = r1; end
      if (md) begin
        m_mode = 2;
        if (m_pv) begin em = 1'b1; b = m_pb; m_pv = 1'b0; end
      end else if (tk) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == STEP) begin
          m_cnt = 0;
          em = 1'b1;
          if (m_pv) begin
            b = m_pb; m_pv = 1'b0;
          end else begin
            b = m_pat[m_idx];
            m_idx = (m_idx == 0) ? 7 : m_idx - 1;
          end
        end
      end
    end
    m_en = em;
    m_din = b;
    if (em) begin
      m_shadow = {m_shadow[6:0], b};
      if (m_scnt != 65535) m_scnt = m_scnt + 1;
    end
  endtask

  logic [5:0] ins;
  logic [7:0] pv;
  logic       prev_en;
  int         gap;
  int         r;

  initial begin
    // Directed table from reset: tick steps, pending, match, load_err, HOLD, stop
    add(R1|R0, 8'h00, 2'b11, 2'd0, 2'b00, 8'h01, 1'b0);
    add(NO,    8'h00, 2'b00, 2'd0, 2'b00, 8'h01, 1'b0);
    add(LD,    8'hB2, 2'b00, 2'd0, 2'b00, 8'h01, 1'b0);
    add(MD,    8'h00, 2'b00, 2'd1, 2'b00, 8'h01, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h01, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'h03, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h03, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h06, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h06, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'h0D, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h0D, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'h1B, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h1B, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h36, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h36, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h6C, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h6C, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'hD9, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'hD9, 1'b1);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'hB2, 1'b1);
    add(NO,    8'h00, 2'b00, 2'd1, 2'b00, 8'hB2, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'hB2, 1'b0);
    add(R0,    8'h00, 2'b00, 2'd1, 2'b10, 8'hB2, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h64, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h64, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'hC9, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'hC9, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h92, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h92, 1'b0);
    add(TK|R1, 8'h00, 2'b11, 2'd1, 2'b00, 8'h25, 1'b0);
    add(LD,    8'hFF, 2'b00, 2'd1, 2'b01, 8'h25, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h25, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'h4B, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h4B, 1'b0);
    add(TK,    8'h00, 2'b11, 2'd1, 2'b00, 8'h97, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'h97, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h2E, 1'b0);
    add(R1,    8'h00, 2'b00, 2'd1, 2'b10, 8'h2E, 1'b0);
    add(MD,    8'h00, 2'b11, 2'd2, 2'b00, 8'h5D, 1'b0);
    add(NO,    8'h00, 2'b00, 2'd2, 2'b00, 8'h5D, 1'b0);
    add(LD,    8'h0F, 2'b00, 2'd2, 2'b00, 8'h5D, 1'b0);
    add(R0,    8'h00, 2'b10, 2'd2, 2'b00, 8'hBA, 1'b0);
    add(MD,    8'h00, 2'b00, 2'd1, 2'b00, 8'hBA, 1'b0);
    add(TK,    8'h00, 2'b00, 2'd1, 2'b00, 8'hBA, 1'b0);
    add(TK,    8'h00, 2'b10, 2'd1, 2'b00, 8'h74, 1'b0);
    add(R0,    8'h00, 2'b00, 2'd1, 2'b10, 8'h74, 1'b0);
    add(SP|MD, 8'h00, 2'b00, 2'd0, 2'b00, 8'h74, 1'b0);
    add(MD,    8'h00, 2'b00, 2'd1, 2'b00, 8'h74, 1'b0);
    add(SP,    8'h00, 2'b00, 2'd0, 2'b00, 8'h74, 1'b0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ins, tbl[i].pat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            32'({sh_en, sh_din & tbl[i].en_din[1], state, pending, load_err, shadow, match}),
            32'({tbl[i].en_din, tbl[i].st, tbl[i].pd_le, tbl[i].sh, tbl[i].m}));
    end
    drive(NO, 8'h00);

    // Asynchronous reset in the middle of playback with shadow=A5
    do_reset();
    drive(LD, 8'hA5);
    @(posedge clk); #1;
    drive(MD, 8'h00);
    @(posedge clk); #1;
    drive(TK, 8'h00);
    repeat (16) begin
      @(posedge clk); #1;
    end
    drive(NO, 8'h00);
    @(posedge clk); #1;
    check("a5_before_rst", 32'({state, shadow}), 32'({2'd1, 8'hA5}));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_outs", 32'({sh_din, sh_en, state, pending, load_err, shadow, match}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("after_release", 32'({state, shadow}), 32'd0);

    // Randomized stimulus against the model; events separated by idle cycles
    do_reset();
    model_reset();
    gap = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ins = NO;
      pv = 8'h00;
      if (gap == 0) begin
        r = $urandom_range(0, 99);
        if (r < 40)      ins = TK;
        else if (r < 48) ins = R1;
        else if (r < 56) ins = R0;
        else if (r < 60) ins = R1 | R0;
        else if (r < 66) ins = ($urandom_range(0, 1) == 1) ? (TK | R1) : (TK | R0);
        else if (r < 78) ins = MD;
        else if (r < 82) ins = SP;
        else if (r < 96) begin ins = LD; pv = 8'($urandom); end
        else             ins = SP | MD;
        gap = $urandom_range(1, 3);
      end else begin
        gap = gap - 1;
      end
      drive(ins, pv);
      @(posedge clk);
      #1;
      model_step(ins, pv);
      check($sformatf("rand%0d", c),
            32'({sh_en, sh_din & m_en, state, pending, load_err, shadow, match}),
            32'({m_en, m_din, 2'(m_mode), m_pv, m_lerr, m_shadow, m_match}));
`ifdef SHIFT_CNT_EN
      check($sformatf("rand_cnt%0d", c), 32'(shift_cnt), 32'(m_scnt));
`endif
      check($sformatf("no_back2back%0d", c), 32'(prev_en & sh_en), 32'd0);
      prev_en = sh_en;
    end
    drive(NO, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
